// File: rtl/seq_gen.sv
// seq_gen: serial pattern generator.
// Loads a WIDTH-bit pattern, emits bits len..0 MSB-first on `a` (valid high),
// repeats the pattern `repeats` extra times, then pulses `done` for one clock.
// Optional feature: define SEQ_GEN_GAP_EN to insert one idle (GAP) step between
// repetitions; without it repetitions are back-to-back.
module seq_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     start,
    input  logic [WIDTH-1:0]         pattern,
    input  logic [$clog2(WIDTH)-1:0] len,
    input  logic [CNT_W-1:0]         repeats,
    output logic                     a,
    output logic                     valid,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned LEN_W = $clog2(WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef SEQ_GEN_GAP_EN
    localparam logic [1:0] GAP   = 2'd2;
`endif

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0] len_q,     len_d;
    logic [LEN_W-1:0] index_q,   index_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             a_q,       a_d;
    logic             valid_q,   valid_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    // Next-state logic: everything advances only on enabled edges, except done which self-clears.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        index_d   = index_q;
        count_d   = count_q;
        done_d    = 1'b0;

        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pattern_d = pattern;
                        len_d     = len;
                        index_d   = len;
                        count_d   = repeats;
                        state_d   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (index_q != '0) begin
                        index_d = index_q - LEN_W'(1);
                    end else if (count_q != '0) begin
                        count_d = count_q - CNT_W'(1);
                        index_d = len_q;
`ifdef SEQ_GEN_GAP_EN
                        state_d = GAP;
`endif
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
`ifdef SEQ_GEN_GAP_EN
                GAP: begin
                    state_d = SHIFT;
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode of the next state, so the registered outputs track the registered state exactly.
    always_comb begin
        valid_d = (state_d == SHIFT);
        busy_d  = (state_d != IDLE);
        a_d     = (state_d == SHIFT) ? pattern_d[index_d] : 1'b0;
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            index_q   <= '0;
            count_q   <= '0;
            a_q       <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            index_q   <= index_d;
            count_q   <= count_d;
            a_q       <= a_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign a     = a_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Testbench for seq_gen: directed scenarios plus randomized traffic against a
// queue-based reference model. Honors SEQ_GEN_GAP_EN when defined.
module tb_seq_gen;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LEN_W = $clog2(WIDTH);

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] repeats;
    logic             a;
    logic             valid;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of per-step expected items {valid, a}.
    logic [1:0] m_q[$];
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;

    // Stream collector for directed scenarios.
    logic [31:0] got;
    int          nvalid;
    int          ndone;
    int          nbusy;

    seq_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .repeats (repeats),
        .a       (a),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_busy = 1'b0;
        m_done = 1'b0;
    endtask

    // One clock edge of the model, using the input values the DUT saw at this edge.
    task automatic model_edge();
        m_done = 1'b0;
        if (reset) begin
            model_clear();
        end else if (enable) begin
            if (m_busy) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (start) begin
                for (int r = 0; r <= int'(repeats); r++) begin
`ifdef SEQ_GEN_GAP_EN
                    if (r > 0) m_q.push_back(2'b00);
`endif
                    for (int b = int'(len); b >= 0; b--) m_q.push_back({1'b1, pattern[b]});
                end
                m_busy = 1'b1;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [1:0] item;
        item = m_busy ? m_q[0] : 2'b00;
        check_eq("busy",  32'(busy),  32'(m_busy));
        check_eq("valid", 32'(valid), 32'(item[1]));
        check_eq("a",     32'(a),     32'(item[0]));
        check_eq("done",  32'(done),  32'(m_done));
    endtask

    task automatic collect_clear();
        got    = '0;
        nvalid = 0;
        ndone  = 0;
        nbusy  = 0;
    endtask

    // Advance one clock, update the model, check outputs #1 after the edge.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_outputs();
        if (valid) begin
            got = {got[30:0], a};
            nvalid++;
        end
        if (done) ndone++;
        if (busy) nbusy++;
    endtask

    // Reset asserted mid-cycle: outputs must clear without a clock edge.
    task automatic mid_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_eq({tag, "_a"},     32'(a),     32'd0);
        check_eq({tag, "_valid"}, 32'(valid), 32'd0);
        check_eq({tag, "_busy"},  32'(busy),  32'd0);
        check_eq({tag, "_done"},  32'(done),  32'd0);
        step();
        step();
        #2;
        reset = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] l, input logic [CNT_W-1:0] r);
        pattern = p;
        len     = l;
        repeats = r;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        start   = 1'b0;
        pattern = '0;
        len     = '0;
        repeats = '0;
        #1;
        check_eq("rst_a",     32'(a),     32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_busy",  32'(busy),  32'd0);
        check_eq("rst_done",  32'(done),  32'd0);
        step();
        step();
        #2;
        reset  = 1'b0;
        enable = 1'b1;
        step();

        // Single pattern 0x0B, len 3: stream 1,0,1,1 with 1-clock latency.
        collect_clear();
        send(8'h0B, 3'd3, 4'd0);
        check_eq("lat_valid", 32'(valid), 32'd1);
        check_eq("lat_a",     32'(a),     32'd1);
        for (int i = 0; i < 6; i++) step();
        check_eq("single_bits",  got,          32'hB);
        check_eq("single_nbits", 32'(nvalid),  32'd4);
        check_eq("single_busy",  32'(nbusy),   32'd4);
        check_eq("single_done",  32'(ndone),   32'd1);

        // Repeats: 0x02, len 1, repeats 2.
        collect_clear();
        send(8'h02, 3'd1, 4'd2);
        for (int i = 0; i < 12; i++) step();
        check_eq("rep_bits",  got,         32'b101010);
        check_eq("rep_nbits", 32'(nvalid), 32'd6);
`ifdef SEQ_GEN_GAP_EN
        check_eq("rep_busy",  32'(nbusy),  32'd8);
`else
        check_eq("rep_busy",  32'(nbusy),  32'd6);
`endif
        check_eq("rep_done",  32'(ndone),  32'd1);

        // Enable throttling: each bit held two cycles, done still a single pulse.
        collect_clear();
        send(8'h0B, 3'd3, 4'd0);
        for (int i = 0; i < 14; i++) begin
            enable = (i % 2 == 1);
            step();
        end
        enable = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check_eq("thr_bits",  got,         32'b11001111);
        check_eq("thr_nbits", 32'(nvalid), 32'd8);
        check_eq("thr_done",  32'(ndone),  32'd1);

        // Start while busy with a different pattern is ignored.
        collect_clear();
        send(8'h0B, 3'd3, 4'd0);
        pattern = 8'hFF;
        len     = 3'd7;
        repeats = 4'd3;
        start   = 1'b1;
        for (int i = 0; i < 3; i++) step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_eq("busy_bits",  got,         32'hB);
        check_eq("busy_nbits", 32'(nvalid), 32'd4);
        check_eq("busy_done",  32'(ndone),  32'd1);

        // Back-to-back: start held high re-accepts one idle cycle after done.
        collect_clear();
        pattern = 8'h01;
        len     = 3'd0;
        repeats = 4'd0;
        start   = 1'b1;
        for (int i = 0; i < 5; i++) step();
        start = 1'b0;
        step();
        step();
        check_eq("b2b_nbits", 32'(nvalid), 32'd3);
        check_eq("b2b_done",  32'(ndone),  32'd3);

        // Abort after two bits: no done pulse, then a clean full transmission.
        collect_clear();
        send(8'h0B, 3'd3, 4'd0);
        step();
        mid_reset("abort");
        for (int i = 0; i < 4; i++) step();
        check_eq("abort_nbits", 32'(nvalid), 32'd2);
        check_eq("abort_done",  32'(ndone),  32'd0);
        collect_clear();
        send(8'h0B, 3'd3, 4'd0);
        for (int i = 0; i < 6; i++) step();
        check_eq("after_bits", got,        32'hB);
        check_eq("after_done", 32'(ndone), 32'd1);

        // Reset and start together: reset wins.
        reset = 1'b1;
        start = 1'b1;
        step();
        check_eq("rst_start_busy", 32'(busy), 32'd0);
        #2;
        reset = 1'b0;
        start = 1'b0;
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            enable  = ($urandom_range(0, 3) != 0);
            start   = ($urandom_range(0, 2) == 0);
            pattern = WIDTH'($urandom);
            len     = LEN_W'($urandom);
            repeats = CNT_W'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) mid_reset("rnd_rst");
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the pattern register width; it must be a power of two and at least 2.
REQ-002 The module SHALL have parameter CNT_W, default 4, giving the repeat counter width.
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port enable, input, 1 bit: step strobe; the FSM and counters advance only on edges where enable=1.
REQ-006 The module SHALL have port start, input, 1 bit: transmission request.
REQ-007 The module SHALL have port pattern, input, WIDTH bits: the bit pattern to emit.
REQ-008 The module SHALL have port len, input, $clog2(WIDTH) bits: number of pattern bits minus 1.
REQ-009 The module SHALL have port repeats, input, CNT_W bits: number of additional repetitions.
REQ-010 The module SHALL have port a, output, 1 bit: the serial bit stream, in the form the team's sequence detectors consume.
REQ-011 The module SHALL have port valid, output, 1 bit: a carries a pattern bit.
REQ-012 The module SHALL have port busy, output, 1 bit: a transmission is in progress.
REQ-013 The module SHALL have port done, output, 1 bit: one-clock pulse when a transmission completes.

Function
REQ-014 The FSM SHALL have states IDLE and SHIFT, plus GAP only when SEQ_GEN_GAP_EN is defined.
REQ-015 In IDLE, an edge with enable=1 and start=1 SHALL capture pattern, len and repeats into internal registers, set bit index = len and repetition count = repeats, and enter SHIFT.
REQ-016 The outputs a, valid and busy SHALL be decoded from registered state only: valid = (state==SHIFT); a = pattern_r[index] in SHIFT, else 0; busy = (state!=IDLE).
REQ-017 The first bit SHALL appear on a in the cycle after the accepting edge, giving a latency of exactly 1 clock.
REQ-018 Bits SHALL be emitted MSB-first, from pattern_r[len_r] down to pattern_r[0]; bits above len_r are ignored.
REQ-019 On an enabled edge in SHIFT with index>0, index SHALL decrement.
REQ-020 On an enabled edge in SHIFT with index==0 and count>0, count SHALL decrement and index SHALL reload to len_r (entering GAP first if SEQ_GEN_GAP_EN is defined).
REQ-021 On an enabled edge in SHIFT with index==0 and count==0, the FSM SHALL return to IDLE and done SHALL be 1 for exactly the following clock cycle.
REQ-022 done SHALL be registered and clear after one clock regardless of enable.
REQ-023 Total valid bits per transmission SHALL be (len+1)*(repeats+1), with no arithmetic wrap; len=0 yields single-bit patterns.
REQ-024 When enable=0, all state, index, count and outputs other than done SHALL hold.
REQ-025 start while busy=1 SHALL be ignored, and changes to pattern, len or repeats while busy=1 SHALL have no effect.
REQ-026 start SHALL be accepted on the edge after done pulses, allowing back-to-back transmissions with one IDLE cycle between them.

Reset
REQ-027 reset=1 SHALL immediately, without a clock, force state IDLE, index 0, count 0, a=0, valid=0, busy=0, done=0.
REQ-028 A reset during SHIFT SHALL abort the transmission without a done pulse.
REQ-029 When reset and start are active together, reset SHALL win.

Configuration
REQ-030 With macro SEQ_GEN_GAP_EN defined, each repetition boundary other than the last SHALL insert one enabled step in GAP with valid=0, a=0, busy=1, then return to SHIFT.
REQ-031 With SEQ_GEN_GAP_EN undefined, the GAP state SHALL not exist and repetitions SHALL be back-to-back.

Verification
REQ-032 Reset scenario: assert reset mid-cycle -> a=0, valid=0, busy=0, done=0 immediately.
REQ-033 Single pattern: pattern=8'h0B, len=3, repeats=0, enable=1, pulse start -> a=1,0,1,1 with valid=1 for 4 cycles; done=1 in cycle 5; busy high for 4 cycles.
REQ-034 Repeats: pattern=8'h02, len=1, repeats=2 -> without macro a=1,0,1,0,1,0 over 6 valid cycles; with macro 8 cycles, valid=0 in cycles 3 and 6.
REQ-035 Enable throttling: enable toggling 1,0,1,0 during REQ-033 stimulus -> each bit held 2 cycles; done remains a single-cycle pulse.
REQ-036 Busy start: start with pattern=8'hFF while sending 8'h0B -> output stream unchanged; no restart.
REQ-037 Abort: assert reset after 2 bits -> outputs 0, no done; next start transmits the full pattern correctly.
